// File: rtl/ibex_prefetch_req_ctrl.sv
// Prefetch request controller: issues word-aligned instruction fetches, tracks
// outstanding responses and forwards the surviving ones into the fetch FIFO.
module ibex_prefetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i
);

    localparam int unsigned      CNT_W   = $clog2(NUM_REQS + 1);
    localparam int unsigned      OCC_W   = $clog2(2 * NUM_REQS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_REQS);
    localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(NUM_REQS);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_GNT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [31:0]         stored_addr_q, stored_addr_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic                stale_q, stale_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, append_idx;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic [OCC_W-1:0]    occ;
    logic [31:0]         branch_addr;
    logic                grant;
    logic                stale_grant;

    assign branch_addr = {addr_i[31:2], 2'b00};

    always_comb begin
        occ = OCC_W'(cnt_q);
        for (int i = 0; i < NUM_REQS; i++) begin
            occ = occ + OCC_W'(fifo_busy_i[i]);
        end
    end

    // A branch bypasses the FIFO fill check: the FIFO is cleared this same cycle.
    always_comb begin
        if (state_q == WAIT_GNT) begin
            instr_req_o  = 1'b1;
            instr_addr_o = stored_addr_q;
        end else begin
            instr_req_o  = req_i & (cnt_q < MAX_CNT) & (branch_i | (occ < MAX_OCC));
            instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
        end
    end

    assign grant       = instr_req_o & instr_gnt_i;
    assign stale_grant = grant & (state_q == WAIT_GNT) & (stale_q | branch_i);
    assign append_idx  = instr_rvalid_i ? cnt_q - CNT_W'(1) : cnt_q;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        stored_addr_d = stored_addr_q;
        if (state_q == IDLE) begin
            if (instr_req_o && !instr_gnt_i) begin
                state_d       = WAIT_GNT;
                stored_addr_d = instr_addr_o;
            end
        end else if (instr_gnt_i) begin
            state_d = IDLE;
        end

        stale_d = (state_q == WAIT_GNT) & ~instr_gnt_i & (stale_q | branch_i);

        // A stale grant must not advance past the branch target.
        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = branch_addr;
        end
        if (grant && !stale_grant) begin
            fetch_addr_d = instr_addr_o + 32'd4;
        end

        unique case ({grant, instr_rvalid_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Mark old stream, pop the head, then append the new grant.
        discard_d = discard_q;
        if (branch_i) begin
            discard_d = '1;
        end
        if (instr_rvalid_i) begin
            discard_d = discard_d >> 1;
        end
        if (grant) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CNT_W'(i) == append_idx) begin
                    discard_d[i] = stale_grant;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            stored_addr_q <= '0;
            fetch_addr_q  <= '0;
            stale_q       <= 1'b0;
            cnt_q         <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            stored_addr_q <= stored_addr_d;
            fetch_addr_q  <= fetch_addr_d;
            stale_q       <= stale_d;
            cnt_q         <= cnt_d;
            discard_q     <= discard_d;
        end
    end

    assign busy_o       = (state_q == WAIT_GNT) | (cnt_q != '0);
    assign fifo_clear_o = branch_i;
    assign fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    // Bus protocol violations: response with nothing outstanding, grant when full.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_rvalid_i && cnt_q == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(grant && cnt_q == MAX_CNT));

endmodule

// File: tb/tb_ibex_prefetch_req_ctrl.sv
// Bench for ibex_prefetch_req_ctrl: vector table plus multi-cycle sequences,
// FIFO pushes checked against a scoreboard queue.
module tb_ibex_prefetch_req_ctrl;

    localparam int NR = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0]   addr_i, instr_rdata_i;
    logic [NR-1:0] fifo_busy_i;
    logic          busy_o, instr_req_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
    logic [31:0]   instr_addr_o, fifo_addr_o, fifo_rdata_o;

    ibex_prefetch_req_ctrl #(.NUM_REQS(NR)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .fifo_busy_i    (fifo_busy_i)
    );

    always #5 clk_i = ~clk_i;

    // ctl = {req, branch, gnt, rvalid, err}; exp = {req, valid, clear, busy}
    typedef struct {
        logic [4:0]    ctl;
        logic [31:0]   addr;
        logic [31:0]   rdata;
        logic [NR-1:0] fb;
        logic          push;
        logic [3:0]    exp;
        logic [31:0]   e_addr;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } push_t;

    localparam int NV = 14;
    vec_t  vecs[NV];
    push_t sb[$];
    push_t sb_head;
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] rd,
                         input logic [NR-1:0] fb, input logic push);
        @(posedge clk_i);
        #1;
        {req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i} = ctl;
        addr_i        = a;
        instr_rdata_i = rd;
        fifo_busy_i   = fb;
        if (push) sb.push_back({rd, ctl[0]});
        @(negedge clk_i);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e, input logic [31:0] ea);
        check({tag, "_req"},   32'(instr_req_o),  32'(e[3]));
        check({tag, "_valid"}, 32'(fifo_valid_o), 32'(e[2]));
        check({tag, "_clear"}, 32'(fifo_clear_o), 32'(e[1]));
        check({tag, "_busy"},  32'(busy_o),       32'(e[0]));
        check({tag, "_addr"},  instr_addr_o,      ea);
    endtask

    task automatic step(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                        input logic [31:0] rd, input logic push, input logic [3:0] e,
                        input logic [31:0] ea);
        drive(ctl, a, rd, 2'b00, push);
        expect_out(tag, e, ea);
    endtask

    // Scoreboard: every FIFO push must match the oldest expected response.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && fifo_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got %08h expected no push", fifo_rdata_o);
            end else begin
                sb_head = sb.pop_front();
                check("push_rdata", fifo_rdata_o, sb_head.rdata);
                check("push_err", 32'(fifo_err_o), 32'(sb_head.err));
            end
        end
    end

    initial begin
        // Tests 1-3 plus branch bypassing a full FIFO into a stalled grant.
        vecs[0]  = '{5'b11100, 32'h0000_0100, 32'h0,         2'b00, 1'b0, 4'b1010, 32'h0000_0100};
        vecs[1]  = '{5'b10110, 32'h0,         32'hDEAD_BEEF, 2'b00, 1'b1, 4'b1101, 32'h0000_0104};
        vecs[2]  = '{5'b00010, 32'h0,         32'h1111_1111, 2'b00, 1'b1, 4'b0101, 32'h0000_0108};
        vecs[3]  = '{5'b00000, 32'h0,         32'h0,         2'b00, 1'b0, 4'b0000, 32'h0000_0108};
        vecs[4]  = '{5'b11100, 32'h0000_0202, 32'h0,         2'b00, 1'b0, 4'b1010, 32'h0000_0200};
        vecs[5]  = '{5'b10110, 32'h0,         32'h2222_2222, 2'b00, 1'b1, 4'b1101, 32'h0000_0204};
        vecs[6]  = '{5'b00010, 32'h0,         32'h3333_3333, 2'b00, 1'b1, 4'b0101, 32'h0000_0208};
        vecs[7]  = '{5'b10000, 32'h0,         32'h0,         2'b11, 1'b0, 4'b0000, 32'h0000_0208};
        vecs[8]  = '{5'b10100, 32'h0,         32'h0,         2'b01, 1'b0, 4'b1000, 32'h0000_0208};
        vecs[9]  = '{5'b10100, 32'h0,         32'h0,         2'b01, 1'b0, 4'b0001, 32'h0000_020C};
        vecs[10] = '{5'b00010, 32'h0,         32'h4444_4444, 2'b00, 1'b1, 4'b0101, 32'h0000_020C};
        vecs[11] = '{5'b11000, 32'h0000_0300, 32'h0,         2'b11, 1'b0, 4'b1010, 32'h0000_0300};
        vecs[12] = '{5'b10100, 32'h0,         32'h0,         2'b11, 1'b0, 4'b1001, 32'h0000_0300};
        vecs[13] = '{5'b00010, 32'h0,         32'h5A5A_5A5A, 2'b00, 1'b1, 4'b0101, 32'h0000_0304};

        rst_ni = 1'b0;
        {req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i} = 5'b00000;
        addr_i        = 32'h0;
        instr_rdata_i = 32'h0;
        fifo_busy_i   = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        expect_out("reset", 4'b0000, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ctl, vecs[i].addr, vecs[i].rdata, vecs[i].fb, vecs[i].push);
            expect_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].e_addr);
            check($sformatf("vec%0d_fifo_addr", i), fifo_addr_o, vecs[i].addr);
        end

        // Grant held off at 0x104 while a branch to 0x400 arrives.
        step("s1", 5'b11100, 32'h0000_0100, 32'h0,         1'b0, 4'b1010, 32'h0000_0100);
        step("s2", 5'b10000, 32'h0,         32'h0,         1'b0, 4'b1001, 32'h0000_0104);
        step("s3", 5'b11000, 32'h0000_0400, 32'h0,         1'b0, 4'b1011, 32'h0000_0104);
        step("s4", 5'b00000, 32'h0,         32'h0,         1'b0, 4'b1001, 32'h0000_0104);
        step("s5", 5'b00100, 32'h0,         32'h0,         1'b0, 4'b1001, 32'h0000_0104);
        step("s6", 5'b10010, 32'h0,         32'h5555_5555, 1'b0, 4'b0001, 32'h0000_0400);
        step("s7", 5'b10110, 32'h0,         32'h6666_6666, 1'b0, 4'b1001, 32'h0000_0400);
        step("s8", 5'b00010, 32'h0,         32'h7777_7777, 1'b1, 4'b0101, 32'h0000_0404);

        // Two outstanding, then a branch coinciding with the first response.
        step("t1", 5'b10100, 32'h0,         32'h0,         1'b0, 4'b1000, 32'h0000_0404);
        step("t2", 5'b10100, 32'h0,         32'h0,         1'b0, 4'b1001, 32'h0000_0408);
        step("t3", 5'b11110, 32'h0000_0800, 32'h8888_8888, 1'b0, 4'b0011, 32'h0000_0800);
        step("t4", 5'b10110, 32'h0,         32'h9999_9999, 1'b0, 4'b1001, 32'h0000_0800);
        step("t5", 5'b00010, 32'h0,         32'hAAAA_AAAA, 1'b1, 4'b0101, 32'h0000_0804);
        step("t6", 5'b00000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0000_0804);

        // Address wrap past 0xFFFFFFFC and an error response.
        step("u1", 5'b11100, 32'hFFFF_FFF8, 32'h0,         1'b0, 4'b1010, 32'hFFFF_FFF8);
        step("u2", 5'b10110, 32'h0,         32'hBBBB_BBBB, 1'b1, 4'b1101, 32'hFFFF_FFFC);
        step("u3", 5'b10111, 32'h0,         32'hCCCC_CCCC, 1'b1, 4'b1101, 32'h0000_0000);
        step("u4", 5'b00010, 32'h0,         32'hDDDD_DDDD, 1'b1, 4'b0101, 32'h0000_0004);
        step("u5", 5'b00000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0000_0004);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_prefetch_req_ctrl.md
Name: ibex_prefetch_req_ctrl

Overview:
- Memory-side request controller for the instruction prefetch path, directly upstream of the fetch FIFO.
- Issues word-aligned instruction fetches on a req/gnt/rvalid bus and tracks up to NUM_REQS outstanding responses.
- Throttles issue on the FIFO fill level and discards stale responses after a branch.
- Pushes surviving responses, plus the branch clear/address, into the fetch FIFO's input port.

Parameters:
NUM_REQS, 2, maximum outstanding bus requests; also the width of fifo_busy_i. Legal values are 1 to 4.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  fetch enable from the IF stage
branch_i  in  1  redirect fetch to addr_i (single-cycle pulse)
addr_i  in  32  branch target; may be halfword-aligned
busy_o  out  1  request pending or response outstanding
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus address; bits [1:0] are always 0
instr_rvalid_i  in  1  bus response valid
instr_rdata_i  in  32  bus response data
instr_err_i  in  1  bus response error
fifo_clear_o  out  1  FIFO clear; equals branch_i
fifo_valid_o  out  1  push to FIFO
fifo_addr_o  out  32  equals addr_i; the FIFO samples it only on clear
fifo_rdata_o  out  32  equals instr_rdata_i
fifo_err_o  out  1  equals instr_err_i
fifo_busy_i  in  NUM_REQS  FIFO upper-entry occupancy

Behaviour:
- Reset: every register cleared. After reset, all outputs are 0 except those that combinationally follow inputs: fifo_clear_o, fifo_addr_o, fifo_rdata_o and fifo_err_o. The fetch address register is cleared to 0.
- State machine IDLE/WAIT_GNT:
  - IDLE -> WAIT_GNT when instr_req_o=1 and instr_gnt_i=0.
  - WAIT_GNT -> IDLE on instr_gnt_i.
- Registers: stored_addr_q holds the ungranted address; fetch_addr_q holds the next word address.
- Occupancy: occ = outstanding_cnt + popcount(fifo_busy_i).
- Issue condition in IDLE: instr_req_o = req_i & (outstanding_cnt < NUM_REQS) & (branch_i | occ < NUM_REQS).
  - A branch bypasses the FIFO check, because the FIFO is cleared in that same cycle.
- Address in IDLE: instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q.
- WAIT_GNT: instr_req_o = 1 and instr_addr_o = stored_addr_q, held stable until granted regardless of req_i, branch_i or FIFO state.
- Grant: fetch_addr_q <= instr_addr_o + 4, wrapping modulo 2^32.
  - A granted request enters the in-order outstanding queue (depth NUM_REQS) with discard bit 0.
  - The discard bit is 1 if the granted request is the stale WAIT_GNT address following a branch.
- Branch: fetch_addr_q and the next issue target become {addr_i[31:2],2'b00}.
  - Every queued entry gets discard=1.
  - If branch_i occurs in WAIT_GNT, the held request is flagged stale; on its grant it is queued with discard=1 and fetch_addr_q stays at the branch target.
  - In IDLE, the same-cycle request to the new target is not discarded.
- Response: each instr_rvalid_i pops the queue head.
  - fifo_valid_o = instr_rvalid_i & ~head_discard & ~branch_i.
  - A response in the same cycle as branch_i belongs to the old stream and is dropped.
- Counter: outstanding_cnt increments on grant and decrements on rvalid. A simultaneous grant and rvalid leave it unchanged, with the queue shifting and appending in the same cycle.
- req_i low: no new requests are issued. Outstanding responses still complete and push normally.
- busy_o = (state==WAIT_GNT) | (outstanding_cnt != 0).
- Bus protocol errors: rvalid with outstanding_cnt==0, or grant with outstanding_cnt==NUM_REQS, are illegal and are covered by assertions. An error response is pushed like data, with fifo_err_o=1.

Test Plan:
1. Reset, then req_i=1, branch_i=1, addr_i=0x100, immediate gnt, rvalid one cycle later with rdata=0xDEADBEEF -> requests go to 0x100, 0x104; FIFO push of 0xDEADBEEF; fifo_clear_o=1 only in the branch cycle.
2. addr_i=0x00000202 -> instr_addr_o=0x200; fifo_addr_o=0x202 in the clear cycle; next request goes to 0x204.
3. fifo_busy_i=all ones with outstanding_cnt=0 -> instr_req_o=0; with one bit dropped -> exactly one request issued, then issue stalls.
4. gnt withheld 3 cycles at 0x104 while branch_i to 0x400 arrives -> address held at 0x104 until grant; that response is dropped (fifo_valid_o=0); next request goes to 0x400 and is pushed.
5. Two outstanding requests, then branch_i coinciding with the first rvalid -> neither old response is pushed; the new target response is pushed; outstanding_cnt returns to 0 and busy_o drops.
6. fetch_addr_q=0xFFFFFFFC, gnt -> next request goes to 0x00000000; rvalid with instr_err_i=1 -> push with fifo_err_o=1.
